// File: rtl/crypt_sequencer.sv
// Multi-cycle sequencer for the MIPS Crypt instructions: captures operands, stalls the core,
// iterates an external round function, then presents the result for one write-back cycle.
module crypt_sequencer #(
    parameter  int unsigned ROUNDS = 8,
    localparam int unsigned CW     = $clog2(ROUNDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [31:0]   src_a,
    input  logic [31:0]   src_b,
    output logic          stall,
    output logic          busy,
    output logic [CW-1:0] round_idx,
    output logic          round_dec,
    output logic [31:0]   round_data,
    output logic [31:0]   round_key,
    input  logic [31:0]   round_out,
    output logic [31:0]   result,
    output logic          result_valid,
    output logic [15:0]   crypt_count
);

    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   data_q;
    logic [31:0]   key_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic          dec_q;
    logic          busy_q;
    logic          valid_q;
    logic [15:0]   count_q;
    logic          crypt_hit_c;

    assign crypt_hit_c = instr_valid && (opcode == 6'h00) &&
                         ((funct == 6'h30) || (funct == 6'h31));

    // Stall must cover the decode cycle itself, so it cannot wait for the state register.
    assign stall = ((state == IDLE) && crypt_hit_c) || (state == RUN);

    assign busy         = busy_q;
    assign round_idx    = idx_q;
    assign round_dec    = dec_q;
    assign round_data   = data_q;
    assign round_key    = key_q;
    assign result       = data_q;
    assign result_valid = valid_q;
    assign crypt_count  = count_q;

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (crypt_hit_c) begin
                        data_q <= src_a;
                        key_q  <= src_b;
                        dec_q  <= funct[0];
                        idx_q  <= funct[0] ? LAST : '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    data_q <= round_out;
                    if (cnt_q == LAST) begin
                        // Index and count freeze on the last round so neither ever wraps.
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        idx_q <= dec_q ? (idx_q - CW'(1)) : (idx_q + CW'(1));
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    count_q <= count_q + 16'd1;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Scoreboard bench for crypt_sequencer with ROUNDS=4 and an add/subtract round function.
module tb_crypt_sequencer;

    localparam int unsigned R  = 4;
    localparam int unsigned CW = $clog2(R);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [31:0]   src_a;
    logic [31:0]   src_b;
    logic          stall;
    logic          busy;
    logic [CW-1:0] round_idx;
    logic          round_dec;
    logic [31:0]   round_data;
    logic [31:0]   round_key;
    logic [31:0]   round_out;
    logic [31:0]   result;
    logic          result_valid;
    logic [15:0]   crypt_count;

    int tests  = 0;
    int failed = 0;
    logic [31:0] sb_q[$];

    crypt_sequencer #(.ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .funct(funct), .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
        .round_idx(round_idx), .round_dec(round_dec), .round_data(round_data),
        .round_key(round_key), .round_out(round_out), .result(result),
        .result_valid(result_valid), .crypt_count(crypt_count)
    );

    always #5 clk = ~clk;

    // Bench round function
    always_comb begin
        if (round_dec) round_out = round_data - round_key - 32'(round_idx);
        else           round_out = round_data + round_key + 32'(round_idx);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result_valid cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(result_valid), 32'd0);
            end else begin
                check("sb_result", result, sb_q.pop_front());
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the DONE edge
    task automatic crypt_op(input bit dec, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        instr_valid = 1'b1;
        opcode      = 6'h00;
        funct       = dec ? 6'h31 : 6'h30;
        src_a       = a;
        src_b       = b;
        sb_q.push_back(exp);
        @(negedge clk);
        check("cap_stall", 32'(stall), 32'd1);
        check("cap_busy", 32'(busy), 32'd0);
        for (int k = 0; k < int'(R); k++) begin
            @(negedge clk);
            check("run_stall", 32'(stall), 32'd1);
            check("run_busy", 32'(busy), 32'd1);
            check("run_dec", 32'(round_dec), 32'(dec));
            check("run_idx", 32'(round_idx), dec ? 32'(int'(R) - 1 - k) : 32'(k));
            check("run_valid", 32'(result_valid), 32'd0);
        end
        @(negedge clk);
        check("done_stall", 32'(stall), 32'd0);
        check("done_valid", 32'(result_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        instr_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(result_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
    } instr_t;

    initial begin
        instr_t nc[4];
        nc[0] = '{v: 1'b1, op: 6'h00, fn: 6'h20};
        nc[1] = '{v: 1'b1, op: 6'h23, fn: 6'h30};
        nc[2] = '{v: 1'b0, op: 6'h00, fn: 6'h30};
        nc[3] = '{v: 1'b0, op: 6'h00, fn: 6'h31};

        rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; funct = '0; src_a = '0; src_b = '0;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_idx", 32'(round_idx), 32'd0);
        check("rst_dec", 32'(round_dec), 32'd0);
        check("rst_count", 32'(crypt_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        crypt_op(1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0000_001A);
        idle_cycle();
        check("count_after_enc", 32'(crypt_count), 32'd1);

        crypt_op(1'b1, 32'h0000_001A, 32'h0000_0001, 32'h0000_0010);
        idle_cycle();
        check("count_after_dec", 32'(crypt_count), 32'd2);

        foreach (nc[i]) begin
            instr_valid = nc[i].v; opcode = nc[i].op; funct = nc[i].fn;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("nc_stall", 32'(stall), 32'd0);
                check("nc_busy", 32'(busy), 32'd0);
                check("nc_valid", 32'(result_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
        check("nc_count", 32'(crypt_count), 32'd2);

        // Back-to-back: the second instruction is decoded in the cycle right after DONE
        crypt_op(1'b0, 32'h0000_0100, 32'h0000_0010, 32'h0000_0146);
        crypt_op(1'b1, 32'h0000_0146, 32'h0000_0010, 32'h0000_0100);
        idle_cycle();
        check("b2b_count", 32'(crypt_count), 32'd4);

        // Reset during RUN cycle 2 with the instruction still presented
        instr_valid = 1'b1; opcode = 6'h00; funct = 6'h30;
        src_a = 32'h0000_0010; src_b = 32'h0000_0001;
        @(negedge clk); @(negedge clk); @(negedge clk);
        @(posedge clk); #2;
        check("pre_abort_idx", 32'(round_idx), 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_idx", 32'(round_idx), 32'd0);
        check("abort_count", 32'(crypt_count), 32'd0);
        check("abort_stall_hit", 32'(stall), 32'd1);
        instr_valid = 1'b0;
        #1;
        check("abort_stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycle();
        crypt_op(1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0000_001A);
        idle_cycle();
        check("post_abort_count", 32'(crypt_count), 32'd1);

        // Counter wrap from 0xFFFF
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        @(posedge clk); #1;
        check("preload_count", 32'(crypt_count), 32'h0000_FFFF);
        crypt_op(1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0000_001A);
        idle_cycle();
        check("wrap_count", 32'(crypt_count), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
